// File: rtl/ram_pkg.sv
// Shared constants and state encoding for the multi-read-port RAM.
package ram_pkg;

  localparam int unsigned BYTE = 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ram_state_e;

endpackage

// File: rtl/multi_rd_port_ram_if.sv
// Access bus of the multi-read-port RAM: one byte-enabled write port, NRD read ports.
interface multi_rd_port_ram_if #(
  parameter int unsigned BW  = 32,
  parameter int unsigned AW  = 5,
  parameter int unsigned NRD = 2
);

  logic                clear_req;
  logic                ready;
  logic                write_en;
  logic [BW/8-1:0]     wr_be;
  logic [AW-1:0]       addr_in;
  logic [BW-1:0]       data_in;
  logic [NRD-1:0]      read_en;
  logic [NRD*AW-1:0]   addr_out;
  logic [NRD*BW-1:0]   data_out;
  logic [NRD-1:0]      rd_valid;

  modport master (
    output clear_req, write_en, wr_be, addr_in, data_in, read_en, addr_out,
    input  ready, data_out, rd_valid
  );

  modport slave (
    input  clear_req, write_en, wr_be, addr_in, data_in, read_en, addr_out,
    output ready, data_out, rd_valid
  );

endinterface

// File: rtl/ram_rd_port.sv
// One read port: write-collision bypass mux, registered data and one-cycle valid flag.
module ram_rd_port #(
  parameter int unsigned BW     = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  input  logic [BW-1:0] rd_word,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [BW-1:0] wr_word,
  output logic [BW-1:0] data_out,
  output logic          rd_valid
);

  logic          hit_c;
  logic [BW-1:0] data_d, data_q;
  logic          valid_d, valid_q;

  // wr_en is only ever set for in-range addresses, so a hit never bypasses an out-of-range read
  always_comb begin : rd_next
    hit_c   = (BYPASS != 0) && wr_en && (wr_addr == rd_addr);
    data_d  = data_q;
    valid_d = rd_en;
    if (rd_en) begin
      data_d = hit_c ? wr_word : rd_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin : rd_regs
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_out = data_q;
  assign rd_valid = valid_q;

endmodule

// File: rtl/multi_rd_port_ram.sv
// Byte-enabled single-write / multi-read RAM with a self-zeroing INIT sweep after reset or clear.
module multi_rd_port_ram
  import ram_pkg::*;
#(
  parameter int unsigned BW     = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned DEPTH  = 2**AW,
  parameter int unsigned NRD    = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic               clk,
  input  logic               rst,
  multi_rd_port_ram_if.slave bus
);

  localparam int unsigned   NB      = BW / BYTE;
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  ram_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;

  logic [BW-1:0] mem_q [DEPTH];

  logic          run_c;
  logic          wr_in_range_c;
  logic          run_we_c;
  logic          mem_we_c;
  logic [AW-1:0] mem_waddr_c;
  logic [BW-1:0] old_word_c;
  logic [BW-1:0] merged_c;
  logic [BW-1:0] mem_wdata_c;

  logic [BW-1:0] port_data [NRD];
  logic          port_vld  [NRD];

  always_comb begin : fsm_next
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_RUN: begin
        if (bus.clear_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
    endcase
    ready_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin : fsm_regs
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // A write in the clear cycle is dropped: the sweep that follows zeroes everything anyway
  always_comb begin : wr_merge
    run_c         = (state_q == ST_RUN);
    wr_in_range_c = ({1'b0, bus.addr_in} < DEPTH_W);
    old_word_c    = wr_in_range_c ? mem_q[bus.addr_in] : '0;
    merged_c      = old_word_c;
    for (int k = 0; k < NB; k++) begin
      if (bus.wr_be[k]) begin
        merged_c[k*BYTE +: BYTE] = bus.data_in[k*BYTE +: BYTE];
      end
    end
    run_we_c    = run_c && bus.write_en && !bus.clear_req && wr_in_range_c;
    mem_we_c    = !run_c || run_we_c;
    mem_waddr_c = run_c ? bus.addr_in : cnt_q;
    mem_wdata_c = run_c ? merged_c : '0;
  end

  always_ff @(posedge clk) begin : mem_write
    if (mem_we_c) begin
      mem_q[mem_waddr_c] <= mem_wdata_c;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] raddr_c;
    logic [BW-1:0] rword_c;

    assign raddr_c = bus.addr_out[p*AW +: AW];
    assign rword_c = ({1'b0, raddr_c} < DEPTH_W) ? mem_q[raddr_c] : '0;

    ram_rd_port #(
      .BW     (BW),
      .AW     (AW),
      .BYPASS (BYPASS)
    ) u_rd_port (
      .clk      (clk),
      .rst      (rst),
      .rd_en    (bus.read_en[p] & run_c),
      .rd_addr  (raddr_c),
      .rd_word  (rword_c),
      .wr_en    (run_we_c),
      .wr_addr  (bus.addr_in),
      .wr_word  (merged_c),
      .data_out (port_data[p]),
      .rd_valid (port_vld[p])
    );
  end

  always_comb begin : out_pack
    bus.data_out = '0;
    bus.rd_valid = '0;
    for (int p = 0; p < NRD; p++) begin
      bus.data_out[p*BW +: BW] = port_data[p];
      bus.rd_valid[p]          = port_vld[p];
    end
  end

  assign bus.ready = ready_q;

endmodule

// File: tb/tb_multi_rd_port_ram.sv
// Checks three RAM configurations (write-first, read-first, DEPTH=24) against a shared array model.
module tb_multi_rd_port_ram;

  localparam int unsigned BW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NRD  = 2;
  localparam int unsigned NDUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        clear_req;
  logic        write_en;
  logic [3:0]  wr_be;
  logic [4:0]  addr_in;
  logic [31:0] data_in;
  logic [1:0]  read_en;
  logic [9:0]  addr_out;

  multi_rd_port_ram_if #(.BW(BW), .AW(AW), .NRD(NRD)) bus0 ();
  multi_rd_port_ram_if #(.BW(BW), .AW(AW), .NRD(NRD)) bus1 ();
  multi_rd_port_ram_if #(.BW(BW), .AW(AW), .NRD(NRD)) bus2 ();

  assign bus0.clear_req = clear_req;  assign bus1.clear_req = clear_req;  assign bus2.clear_req = clear_req;
  assign bus0.write_en  = write_en;   assign bus1.write_en  = write_en;   assign bus2.write_en  = write_en;
  assign bus0.wr_be     = wr_be;      assign bus1.wr_be     = wr_be;      assign bus2.wr_be     = wr_be;
  assign bus0.addr_in   = addr_in;    assign bus1.addr_in   = addr_in;    assign bus2.addr_in   = addr_in;
  assign bus0.data_in   = data_in;    assign bus1.data_in   = data_in;    assign bus2.data_in   = data_in;
  assign bus0.read_en   = read_en;    assign bus1.read_en   = read_en;    assign bus2.read_en   = read_en;
  assign bus0.addr_out  = addr_out;   assign bus1.addr_out  = addr_out;   assign bus2.addr_out  = addr_out;

  multi_rd_port_ram #(.BW(BW), .AW(AW), .DEPTH(32), .NRD(NRD), .BYPASS(1)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0));
  multi_rd_port_ram #(.BW(BW), .AW(AW), .DEPTH(32), .NRD(NRD), .BYPASS(0)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1));
  multi_rd_port_ram #(.BW(BW), .AW(AW), .DEPTH(24), .NRD(NRD), .BYPASS(1)) dut2 (
    .clk (clk), .rst (rst), .bus (bus2));

  logic              obs_ready [NDUT];
  logic [NRD*BW-1:0] obs_dout  [NDUT];
  logic [NRD-1:0]    obs_vld   [NDUT];

  assign obs_ready[0] = bus0.ready;  assign obs_dout[0] = bus0.data_out;  assign obs_vld[0] = bus0.rd_valid;
  assign obs_ready[1] = bus1.ready;  assign obs_dout[1] = bus1.data_out;  assign obs_vld[1] = bus1.rd_valid;
  assign obs_ready[2] = bus2.ready;  assign obs_dout[2] = bus2.data_out;  assign obs_vld[2] = bus2.rd_valid;

  int checks = 0;
  int errors = 0;

  // Reference model: plain memory array, remaining-sweep counter and expected port outputs
  logic [31:0]    m_mem  [NDUT][32];
  bit             m_ready[NDUT];
  int             m_cnt  [NDUT];
  logic [31:0]    m_dout [NDUT][NRD];
  logic [NRD-1:0] m_vld  [NDUT];

  function automatic int dep(input int i);
    return (i == 2) ? 24 : 32;
  endfunction

  function automatic bit byp(input int i);
    return (i != 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NDUT; i++) begin
      if (rst) begin
        m_ready[i] = 1'b0;
        m_cnt[i]   = 0;
        m_vld[i]   = '0;
        for (int p = 0; p < NRD; p++) m_dout[i][p] = '0;
      end else if (!m_ready[i]) begin
        m_mem[i][m_cnt[i]] = '0;
        if (m_cnt[i] == dep(i) - 1) begin
          m_ready[i] = 1'b1;
          m_cnt[i]   = 0;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
        m_vld[i] = '0;
      end else begin
        bit          wr;
        logic [31:0] nw;
        wr = write_en && (int'(addr_in) < dep(i)) && !clear_req;
        nw = wr ? m_mem[i][addr_in] : '0;
        for (int k = 0; k < 4; k++) if (wr_be[k]) nw[8*k +: 8] = data_in[8*k +: 8];
        for (int p = 0; p < NRD; p++) begin
          int a;
          a = int'(addr_out[p*5 +: 5]);
          m_vld[i][p] = read_en[p];
          if (read_en[p]) begin
            if (a >= dep(i))                       m_dout[i][p] = '0;
            else if (wr && a == int'(addr_in))     m_dout[i][p] = byp(i) ? nw : m_mem[i][a];
            else                                   m_dout[i][p] = m_mem[i][a];
          end
        end
        if (wr) m_mem[i][addr_in] = nw;
        if (clear_req) begin
          m_ready[i] = 1'b0;
          m_cnt[i]   = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("ready%0d", i), 64'(obs_ready[i]), 64'(m_ready[i]));
      chk($sformatf("rd_valid%0d", i), 64'(obs_vld[i]), 64'(m_vld[i]));
      chk($sformatf("data_out%0d", i), 64'(obs_dout[i]), {m_dout[i][1], m_dout[i][0]});
    end
  endtask

  task automatic idle();
    clear_req = 1'b0;
    write_en  = 1'b0;
    read_en   = '0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    write_en = 1'b1; addr_in = a; data_in = d; wr_be = be;
    step();
    write_en = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a0, input logic [4:0] a1);
    read_en = 2'b11; addr_out = {a1, a0};
    step();
    read_en = '0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!obs_ready[0] && n < 100) begin
      step();
      n++;
    end
    chk(tag, 64'(n), 64'd32);
  endtask

  task automatic read_all();
    for (int a = 0; a < 32; a++) do_read(5'(a), 5'(31 - a));
  endtask

  function automatic logic [4:0] pick_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 2) return addr_in;
    if (r < 4) return 5'($urandom_range(20, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    rst = 1'b1; idle(); wr_be = '0; addr_in = '0; data_in = '0; addr_out = '0;
    step();
    step();
    rst = 1'b0;
    wait_ready("init_len");
    read_all();

    // byte-enable merge on addr 3
    do_write(5'd3, 32'hDEADBEEF, 4'hF);
    do_write(5'd3, 32'h00001200, 4'b0010);
    do_read(5'd3, 5'd3);
    chk("be_merge", 64'(obs_dout[0][31:0]), 64'h0000_0000_DEAD12EF);

    // same-cycle write/read collision on addr 5
    do_write(5'd5, 32'h11111111, 4'hF);
    write_en = 1'b1; addr_in = 5'd5; data_in = 32'h22222222; wr_be = 4'hF;
    read_en = 2'b11; addr_out = {5'd5, 5'd5};
    step();
    idle();
    chk("bypass_wf", 64'(obs_dout[0]), 64'h22222222_22222222);
    chk("bypass_rf", 64'(obs_dout[1]), 64'h11111111_11111111);

    // out-of-range write/read on the DEPTH=24 instance
    do_write(5'd23, 32'hA5A50023, 4'hF);
    do_write(5'd30, 32'h30303030, 4'hF);
    do_read(5'd30, 5'd23);
    chk("oor_data", 64'(obs_dout[2]), 64'hA5A50023_00000000);
    chk("oor_vld", 64'(obs_vld[2]), 64'd3);

    repeat (400) begin
      write_en = 1'($urandom);
      wr_be    = 4'($urandom);
      addr_in  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(20, 31)) : 5'($urandom_range(0, 7));
      data_in  = $urandom;
      read_en  = 2'($urandom);
      addr_out = {pick_addr(), pick_addr()};
      step();
    end
    idle();
    step();

    // clear with a colliding write, reads attempted throughout the sweep
    clear_req = 1'b1; write_en = 1'b1; addr_in = 5'd7; data_in = 32'hFFFFFFFF; wr_be = 4'hF;
    step();
    clear_req = 1'b0; write_en = 1'b0; read_en = 2'b11;
    begin
      int n;
      n = 0;
      while (!obs_ready[0] && n < 100) begin
        addr_out = 10'($urandom);
        step();
        n++;
        if (!obs_ready[0]) chk("clear_vld", 64'(obs_vld[0]), 64'd0);
      end
      chk("clear_len", 64'(n), 64'd32);
    end
    idle();
    read_all();
    do_read(5'd7, 5'd3);
    chk("clear_zero", 64'(obs_dout[0]), 64'd0);

    // reset in the middle of a sweep
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    chk("mid_rst_ready", 64'(obs_ready[0]), 64'd0);
    rst = 1'b0;
    wait_ready("rst_len");
    do_read(5'd0, 5'd31);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_rd_port_ram.md
MULTI_RD_PORT_RAM -- requirements
Module: multi_rd_port_ram

Interface
REQ-001 SHALL have parameter BW, default 32: data word width; a multiple of 8.
REQ-002 SHALL have parameter AW, default 5: address width.
REQ-003 SHALL have parameter DEPTH, default 2**AW: number of words; DEPTH <= 2**AW.
REQ-004 SHALL have parameter NRD, default 2: read port count, 1..8.
REQ-005 SHALL have parameter BYPASS, default 1: 1 = write-first, 0 = read-first on same-address collision.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-008 SHALL have port clear_req, input, 1: synchronous request to re-zero the whole memory.
REQ-009 SHALL have port ready, output, 1: high when initialisation is complete and accesses are accepted.
REQ-010 SHALL have port write_en, input, 1: write strobe.
REQ-011 SHALL have port wr_be, input, BW/8: byte enables; bit k gates data_in[8k+7:8k].
REQ-012 SHALL have port addr_in, input, AW: write address.
REQ-013 SHALL have port data_in, input, BW: write data.
REQ-014 SHALL have port read_en, input, NRD: per-port read strobe.
REQ-015 SHALL have port addr_out, input, NRD*AW: read addresses; port p uses bits [p*AW +: AW].
REQ-016 SHALL have port data_out, output, NRD*BW: read data; port p uses bits [p*BW +: BW].
REQ-017 SHALL have port rd_valid, output, NRD: per-port one-cycle valid flag for data_out.

Function
REQ-018 SHALL implement a two-state FSM: INIT (sweep counter 0..DEPTH-1, one word zeroed per cycle, ready=0) and RUN (ready=1).
REQ-019 SHALL transition INIT->RUN on the cycle after the word at DEPTH-1 is zeroed; INIT therefore lasts exactly DEPTH cycles.
REQ-020 SHALL transition RUN->INIT with the counter at 0 when clear_req=1 is sampled; clear_req is ignored in INIT.
REQ-021 SHALL ignore write_en and read_en while ready=0; rd_valid stays 0 during INIT.
REQ-022 SHALL, in RUN with write_en=1 and addr_in<DEPTH, update only the bytes whose wr_be bit is 1; wr_be=0 is a no-op.
REQ-023 SHALL ignore writes with addr_in>=DEPTH.
REQ-024 SHALL, for each port p in RUN with read_en[p]=1, register the word into data_out[p] and set rd_valid[p]=1 one cycle later (latency 1).
REQ-025 SHALL hold data_out[p] unchanged and drive rd_valid[p]=0 in a cycle following read_en[p]=0.
REQ-026 SHALL return zero and rd_valid=1 for a read with address>=DEPTH.
REQ-027 SHALL, when a read and a write hit the same address in one cycle, return the byte-merged new word if BYPASS=1 and the old word if BYPASS=0, independently per port.
REQ-028 SHALL serve any number of ports reading the same address in one cycle with identical data.
REQ-029 SHALL not let clear_req and a write in the same cycle alter the outcome: the clear wins and the word reads zero after INIT.

Reset
REQ-030 SHALL, on rst=1, asynchronously force state=INIT, sweep counter=0, ready=0, rd_valid=0, data_out=0.
REQ-031 SHALL restart the full DEPTH-cycle sweep from address 0 when rst is asserted mid-sweep or mid-RUN.
REQ-032 SHALL leave memory array contents unreset by rst directly; zeroing is performed only by the INIT sweep.

Structure
REQ-033 SHALL place state encoding (INIT, RUN) and the BYTE=8 constant in shared package ram_pkg.
REQ-034 SHALL use one sub-module, ram_rd_port, instantiated NRD times, containing a port's bypass mux, output register and valid flag.
REQ-035 SHALL keep the memory array, write byte-merge and FSM in the top level.

Verification
REQ-036 SHALL cover: rst pulse, DEPTH=32 -> ready rises after exactly 32 cycles; every address then reads 0x00000000.
REQ-037 SHALL cover: write 0xDEADBEEF to addr 3 (wr_be=4'hF), then wr_be=4'b0010 with data 0x00001200 -> addr 3 reads 0xDEAD12EF.
REQ-038 SHALL cover: BYPASS=1, mem[5]=0x11111111, same-cycle write 0x22222222 to 5 and reads on ports 0 and 1 of 5 -> both ports return 0x22222222; with BYPASS=0 -> both return 0x11111111.
REQ-039 SHALL cover: DEPTH=24, AW=5, write to addr 30, then read addr 30 -> 0x00000000 with rd_valid=1; addr 23 remains intact.
REQ-040 SHALL cover: clear_req in RUN after non-zero writes -> ready low for 32 cycles, reads ignored with rd_valid=0, all words 0 afterward.
REQ-041 SHALL cover: rst asserted at sweep count 10 -> ready stays 0 and the sweep restarts, with ready rising 32 cycles after rst release.
